// File: rtl/sobel_axis_egress_pkg.sv
// Shared definitions for the Sobel egress controller and the conv stage it wraps:
// frame geometry helpers, counter widths and the controller state encoding.
package sobel_axis_egress_pkg;

    localparam int DEF_PIXELS_PER_BEAT = 16;
    localparam int DEF_IMAGE_DIM       = 512;
    localparam int DEF_DATA_WIDTH      = 8 * DEF_PIXELS_PER_BEAT;

    typedef enum logic [1:0] {
        ST_STREAM  = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_REALIGN = 2'd2
    } egress_state_t;

    function automatic int beats_per_row(input int image_dim, input int pixels_per_beat);
        return image_dim / pixels_per_beat;
    endfunction

    function automatic int frame_beats(input int image_dim, input int pixels_per_beat);
        return image_dim * beats_per_row(image_dim, pixels_per_beat);
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_axis_egress_if.sv
// Stream-side handshake bundle of the egress controller: upstream valid/ready
// toward the conv input and the AXI-Stream magnitude output.
interface sobel_axis_egress_if
    import sobel_axis_egress_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    modport master (
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast,
        output m_axis_tuser
    );

    modport slave (
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast,
        input  m_axis_tuser
    );
endinterface

// File: rtl/sobel_axis_egress_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy output; the caller
// guarantees no write when full without a simultaneous read, and no read when empty.
module sobel_axis_egress_sync_fifo_fwft #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    // Storage array, no reset needed on data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/sobel_axis_egress.sv
// Stream controller around the Sobel conv stage: drives its stall, tags beats through
// its fixed-latency pipeline, buffers results and emits AXI-Stream with TLAST/TUSER.
module sobel_axis_egress
    import sobel_axis_egress_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = DEF_PIXELS_PER_BEAT,
    parameter int IMAGE_DIM       = DEF_IMAGE_DIM,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int PIPE_LATENCY    = 8,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    sobel_axis_egress_if.master   axis,
    output logic                  stall,
    output logic                  conv_aresetn,
    input  logic [DATA_WIDTH-1:0] pix_frame
);
    localparam int BPR         = beats_per_row(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int FRAME_BEATS = frame_beats(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int IN_W        = cnt_width(FRAME_BEATS);
    localparam int FL_W        = cnt_width(PIPE_LATENCY);
    localparam int COL_W       = cnt_width(BPR);
    localparam int ROW_W       = cnt_width(IMAGE_DIM);
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IN_W-1:0]  IN_LAST   = IN_W'(FRAME_BEATS - 1);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(PIPE_LATENCY - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(BPR - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMAGE_DIM - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    egress_state_t           state_r;
    logic [IN_W-1:0]         in_cnt_r;
    logic [FL_W-1:0]         flush_cnt_r;
    logic [PIPE_LATENCY-1:0] tag_r;
    logic                    conv_rstn_r;
    logic [COL_W-1:0]        out_col_r;
    logic [ROW_W-1:0]        out_row_r;

    logic [CNT_W-1:0]        fifo_count_s;
    logic [DATA_WIDTH-1:0]   fifo_data_s;
    logic                    fifo_valid_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    full_blk_s;
    logic                    want_s;
    logic                    advance_s;

    // Advance decision; conv_rstn_r low covers both reset and the realign cycle
    always_comb begin
        fifo_valid_s = (fifo_count_s != {CNT_W{1'b0}});
        pop_s        = fifo_valid_s & axis.m_axis_tready;
        full_blk_s   = (fifo_count_s == FIFO_FULL) & ~pop_s;
        case (state_r)
            ST_STREAM: want_s = axis.s_axis_tvalid;
            ST_FLUSH:  want_s = 1'b1;
            default:   want_s = 1'b0;
        endcase
        advance_s = conv_rstn_r & ~full_blk_s & want_s;
        push_s    = advance_s & tag_r[PIPE_LATENCY-1];
    end

    assign stall              = ~advance_s;
    assign conv_aresetn       = conv_rstn_r;
    assign axis.s_axis_tready = (state_r == ST_STREAM) & advance_s;

    // Frame sequencing: stream a frame, flush the conv pipeline, then pulse its reset
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_STREAM;
            in_cnt_r    <= '0;
            flush_cnt_r <= '0;
            conv_rstn_r <= 1'b0;
        end else begin
            conv_rstn_r <= 1'b1;
            case (state_r)
                ST_STREAM: begin
                    if (advance_s) begin
                        if (in_cnt_r == IN_LAST) begin
                            in_cnt_r <= '0;
                            state_r  <= ST_FLUSH;
                        end else begin
                            in_cnt_r <= in_cnt_r + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (advance_s) begin
                        if (flush_cnt_r == FL_LAST) begin
                            flush_cnt_r <= '0;
                            state_r     <= ST_REALIGN;
                            conv_rstn_r <= 1'b0;
                        end else begin
                            flush_cnt_r <= flush_cnt_r + 1'b1;
                        end
                    end
                end
                ST_REALIGN: state_r <= ST_STREAM;
                default:    state_r <= ST_STREAM;
            endcase
        end
    end

    // Tag line mirrors the conv pipeline: a 1 marks a real frame beat, 0 a flush bubble
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tag_r <= '0;
        end else if (state_r == ST_REALIGN) begin
            tag_r <= '0;
        end else if (advance_s) begin
            tag_r[0] <= (state_r == ST_STREAM);
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Row/column position of the beat currently at the FIFO head
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_col_r <= '0;
            out_row_r <= '0;
        end else if (pop_s) begin
            if (out_col_r == COL_LAST) begin
                out_col_r <= '0;
                out_row_r <= (out_row_r == ROW_LAST) ? '0 : out_row_r + 1'b1;
            end else begin
                out_col_r <= out_col_r + 1'b1;
            end
        end
    end

    sobel_axis_egress_sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (push_s),
        .wr_data (pix_frame),
        .rd_en   (pop_s),
        .rd_data (fifo_data_s),
        .count   (fifo_count_s)
    );

    assign axis.m_axis_tdata  = fifo_data_s;
    assign axis.m_axis_tvalid = fifo_valid_s;
    assign axis.m_axis_tlast  = fifo_valid_s & (out_col_r == COL_LAST);
    assign axis.m_axis_tuser  = fifo_valid_s & (out_col_r == {COL_W{1'b0}}) & (out_row_r == {ROW_W{1'b0}});

endmodule

// File: tb/tb_sobel_axis_egress.sv
// Bench for sobel_axis_egress: a frozen-on-stall conv pipeline model feeds pix_frame,
// and every output beat is checked against the queue of accepted input beats.
module tb_sobel_axis_egress;

    localparam int PPB          = 2;
    localparam int IMAGE_DIM    = 64;
    localparam int DW           = 8 * PPB;
    localparam int PIPE_LATENCY = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int BPR          = IMAGE_DIM / PPB;
    localparam int FRAME_BEATS  = IMAGE_DIM * BPR;

    logic          clk;
    logic          aresetn;
    logic          stall;
    logic          conv_aresetn;
    logic [DW-1:0] pix_frame;
    logic [DW-1:0] inp;
    logic [DW-1:0] conv_pipe [PIPE_LATENCY];

    sobel_axis_egress_if #(.DATA_WIDTH(DW)) dif ();

    sobel_axis_egress #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (IMAGE_DIM),
        .DATA_WIDTH      (DW),
        .PIPE_LATENCY    (PIPE_LATENCY),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .axis         (dif),
        .stall        (stall),
        .conv_aresetn (conv_aresetn),
        .pix_frame    (pix_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Conv stage stand-in: fixed-latency pipeline frozen by stall, cleared by conv_aresetn
    always @(posedge clk or negedge conv_aresetn) begin
        if (!conv_aresetn) begin
            for (int i = 0; i < PIPE_LATENCY; i++) conv_pipe[i] <= '0;
        end else if (!stall) begin
            conv_pipe[0] <= inp;
            for (int i = 1; i < PIPE_LATENCY; i++) conv_pipe[i] <= conv_pipe[i-1];
        end
    end
    assign pix_frame = conv_pipe[PIPE_LATENCY-1];

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q [$];
    int            out_idx = 0;
    int            acc_cnt = 0;
    int            tuser_cnt = 0;
    int            tlast_cnt = 0;
    logic          smp_stall, smp_sready, smp_mvalid, smp_crst;
    int            smp_pend;
    int            first_valid, lo_ready, lo_crst, target;
    logic          full_seen, rand_tv, rand_tr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic check_beat();
        logic [DW-1:0] want;
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("tdata", 32'(dif.m_axis_tdata), 32'(want));
            chk("tuser", 32'(dif.m_axis_tuser), 32'((out_idx % FRAME_BEATS) == 0));
            chk("tlast", 32'(dif.m_axis_tlast), 32'((out_idx % BPR) == (BPR - 1)));
        end
        if (dif.m_axis_tuser) tuser_cnt++;
        if (dif.m_axis_tlast) tlast_cnt++;
        out_idx++;
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then cross the posedge
    task automatic cycle(input logic tv, input logic tr);
        logic acc;
        logic pop;
        dif.s_axis_tvalid = tv;
        dif.m_axis_tready = tr;
        inp = DW'($urandom);
        #1;
        smp_stall  = stall;
        smp_sready = dif.s_axis_tready;
        smp_mvalid = dif.m_axis_tvalid;
        smp_crst   = conv_aresetn;
        smp_pend   = exp_q.size();
        acc = tv & dif.s_axis_tready;
        pop = dif.m_axis_tvalid & tr;
        if (pop) check_beat();
        if (acc) begin
            exp_q.push_back(inp);
            acc_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        aresetn = 1'b0;
        dif.s_axis_tvalid = 1'b0;
        dif.m_axis_tready = 1'b0;
        inp = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_sready", 32'(dif.s_axis_tready), 32'd0);
        chk("rst_mvalid", 32'(dif.m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(dif.m_axis_tlast), 32'd0);
        chk("rst_tuser", 32'(dif.m_axis_tuser), 32'd0);
        chk("rst_conv_rstn", 32'(conv_aresetn), 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("conv_rstn_release", 32'(conv_aresetn), 32'd1);

        // Frame 1: continuous input, downstream always ready
        first_valid = -1;
        for (int c = 0; c < FRAME_BEATS; c++) begin
            cycle(1'b1, 1'b1);
            chk("f1_sready", 32'(smp_sready), 32'd1);
            chk("f1_stall", 32'(smp_stall), 32'd0);
            if (smp_mvalid && first_valid < 0) first_valid = c;
        end
        // beat 0 advances at offset 0; tvalid follows the 8th later advance
        chk("first_valid_offset", 32'(first_valid), 32'(PIPE_LATENCY + 1));

        // End of frame: flush bubbles plus one realign cycle
        lo_ready = 0;
        lo_crst = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, 1'b1);
            if (smp_sready) break;
            lo_ready++;
            if (!smp_crst) lo_crst++;
        end
        chk("flush_ready_low", 32'(lo_ready), 32'(PIPE_LATENCY + 1));
        chk("conv_rstn_low", 32'(lo_crst), 32'd1);
        chk("f1_beats_out", 32'(out_idx), 32'(FRAME_BEATS));
        chk("f1_tuser_cnt", 32'(tuser_cnt), 32'd1);
        chk("f1_tlast_cnt", 32'(tlast_cnt), 32'(IMAGE_DIM));

        // Frame 2: downstream backpressure until the FIFO fills
        repeat (100) cycle(1'b1, 1'b1);
        full_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, 1'b0);
            if (full_seen) chk("full_hold_stall", 32'(smp_stall), 32'd1);
            if (smp_stall && !full_seen) begin
                full_seen = 1'b1;
                chk("fill_level", 32'(smp_pend), 32'(FIFO_DEPTH + PIPE_LATENCY));
            end
        end
        chk("full_seen", 32'(full_seen), 32'd1);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b1);
            chk("full_pop_stall", 32'(smp_stall), 32'd0);
            chk("full_pop_level", 32'(smp_pend), 32'(FIFO_DEPTH + PIPE_LATENCY));
        end
        for (int c = 0; c < 3 * FRAME_BEATS && acc_cnt < 2 * FRAME_BEATS; c++) cycle(1'b1, 1'b1);
        chk("f2_accepted", 32'(acc_cnt), 32'(2 * FRAME_BEATS));

        // Frames 3-5: random valid/ready
        target = 5 * FRAME_BEATS;
        for (int c = 0; c < 60000; c++) begin
            rand_tv = (acc_cnt < target) && (($urandom % 32'd100) < 32'd50);
            rand_tr = ($urandom % 32'd100) < 32'd30;
            cycle(rand_tv, rand_tr);
            if (acc_cnt == target && exp_q.size() == 0) break;
        end
        chk("rand_beats", 32'(out_idx - 2 * FRAME_BEATS), 32'(3 * FRAME_BEATS));
        chk("rand_tuser", 32'(tuser_cnt - 2), 32'd3);
        chk("rand_tlast", 32'(tlast_cnt - 2 * IMAGE_DIM), 32'(3 * IMAGE_DIM));

        // Mid-row async reset with FIFO half full
        repeat (12) cycle(1'b0, 1'b1);
        for (int c = 0; c < 2 * PIPE_LATENCY; c++) cycle(1'b1, 1'b0);
        chk("half_full_valid", 32'(dif.m_axis_tvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_mvalid", 32'(dif.m_axis_tvalid), 32'd0);
        chk("arst_tlast", 32'(dif.m_axis_tlast), 32'd0);
        chk("arst_tuser", 32'(dif.m_axis_tuser), 32'd0);
        chk("arst_stall", 32'(stall), 32'd1);
        chk("arst_sready", 32'(dif.s_axis_tready), 32'd0);
        chk("arst_conv_rstn", 32'(conv_aresetn), 32'd0);
        exp_q.delete();
        out_idx = 0;
        acc_cnt = 0;
        tuser_cnt = 0;
        tlast_cnt = 0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 40; c++) cycle(1'b1, 1'b1);
        chk("post_rst_beats", 32'(out_idx > 0), 32'd1);
        chk("post_rst_tuser", 32'(tuser_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
